mul_controller: RTL and testbench
=================================

// Module: mul_controller
// PURPOSE
//   FSM that sequences the repeated-addition multiplier datapath (A reg, P accumulator, B down-counter, eqz).
//   Accepts two operands on the shared 16-bit data_in bus through a valid/ready handshake.
//   Drives ldA/ldB/ldP/clrP/decB until B reaches zero, then signals done; P holds A*B.
// PARAMETERS
//   ITER_W    16       width of the guard iteration counter (MUL_TIMEOUT_EN only)
//   MAX_ITER  65535    max ADD-state cycles before err is raised (MUL_TIMEOUT_EN only)
// PORTS
//   clk       in   1   single clock, rising edge
//   rst_n     in   1   synchronous, active-low reset
//   start     in   1   request a multiply; sampled only in IDLE
//   abort     in   1   return to IDLE next edge from any state
//   in_valid  in   1   upstream drives a valid operand on data_in
//   in_ready  out  1   controller accepts an operand this cycle
//   eqz       in   1   datapath: B counter == 0 (combinational)
//   ldA       out  1   load A from bus
//   ldB       out  1   load B counter from bus
//   ldP       out  1   load P with A+P
//   clrP      out  1   clear P
//   decB      out  1   decrement B counter
//   busy      out  1   high in every state except IDLE
//   done      out  1   one-cycle pulse; product valid in P
//   err       out  1   sticky timeout flag; cleared on next accepted start
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 (err 0); sync reset overrides all inputs.
//   States (3-bit): IDLE, LOAD_A, LOAD_B, ADD, DONE, ERR.
//   IDLE:   start=1 -> LOAD_A. Otherwise stay.
//   LOAD_A: in_ready=1. ldA=in_valid. in_valid -> LOAD_B. Else stall.
//   LOAD_B: in_ready=1. ldB=clrP=in_valid. in_valid -> ADD. Else stall.
//   ADD:    eqz=0 -> ldP=decB=1, stay.
//           eqz=1 -> ldP=decB=0, go DONE. With B=0, P stays 0 and there is no add.
//   DONE:   done=1 for one cycle -> IDLE. P is not touched after DONE.
//   ERR:    err=1 (sticky), all strobes 0 -> IDLE next cycle.
//   Strobes are combinational from state, eqz and in_valid; no strobe is active in IDLE or DONE.
//   Latency: start sampled in cycle 0, in_valid held high -> done in cycle B+4 (B=3 -> cycle 7).
//   start while busy: ignored, never queued. start and abort together in IDLE: abort wins, stay IDLE.
//   abort: next state IDLE, strobes forced 0 that cycle, no done. Datapath registers are not cleared.
//   Reset mid-operation behaves like abort and also clears err.
// CONFIGURATION
//   MUL_TIMEOUT_EN defined:
//     - mul_iter_cnt counts ADD cycles, cleared on entering ADD.
//     - If the count reaches MAX_ITER while eqz=0 -> ERR (err sticky), no done.
//   MUL_TIMEOUT_EN undefined:
//     - No counter is built; err tied 0; ERR state unreachable.
//     - ADD loops until eqz.
// STRUCTURE
//   Package mul_ctrl_pkg:
//     - state encoding constants: IDLE=0, LOAD_A=1, LOAD_B=2, ADD=3, DONE=4, ERR=5
//     - DATA_W=16
//   Sub-module mul_iter_cnt (ITER_W, MAX_ITER): clr, en -> hit. Instantiated only under MUL_TIMEOUT_EN.
//   Top-level bench instantiates mul_controller and MUL_datapath together on the shared data_in bus.
// TESTING
//   1 A=5,B=3, in_valid always high -> done pulse in cycle 7, P=15, busy low the cycle after done.
//   2 A=7,B=0 -> ADD exits on first cycle with no ldP; done in cycle 4; P=0.
//   3 A=9,B=4 with in_valid low 2 cycles in LOAD_A and 3 in LOAD_B -> done delayed 5 cycles; P=36.
//   4 abort during ADD after 2 adds (A=3,B=10) -> IDLE next edge, no done; new start 6*2 -> P=12.
//   5 start pulsed in LOAD_B and ADD -> ignored; exactly one done per accepted start.
//   6 MUL_TIMEOUT_EN, MAX_ITER=8, eqz forced 0 -> err=1 after 8 ADD cycles, no done; next start clears err.

Source files
------------

// File: rtl/mul_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mul_ctrl_pkg
//  Purpose : Shared types and constants for the repeated-addition multiplier
//            controller: state encoding and data bus width.
//  Rev     : 1.0  initial release
// ============================================================================
package mul_ctrl_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/mul_controller_if.sv
`default_nettype none
// ============================================================================
//  Module  : mul_ctrl_if
//  Purpose : Handshake, datapath-strobe and shared operand bus between the
//            multiplier controller (master) and its environment (slave).
//  Rev     : 1.0  initial release
// ============================================================================
interface mul_ctrl_if;
  import mul_ctrl_pkg::*;

  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              eqz;
  logic              ldA;
  logic              ldB;
  logic              ldP;
  logic              clrP;
  logic              decB;
  logic              busy;
  logic              done;
  logic              err;

  // Controller side: never touches the operand bus itself, only strobes loads.
  modport master (
    input  start, abort, in_valid, eqz,
    output in_ready, ldA, ldB, ldP, clrP, decB, busy, done, err
  );

  // Environment side: upstream source plus the multiplier datapath.
  modport slave (
    output start, abort, in_valid, eqz, data_in,
    input  in_ready, ldA, ldB, ldP, clrP, decB, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/mul_controller_iter_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : mul_iter_cnt
//  Purpose : Guard counter for the ADD loop. Cleared on entry to ADD, counts
//            every ADD cycle and flags the cycle that completes MAX_ITER adds.
//            Only built when MUL_TIMEOUT_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
`ifdef MUL_TIMEOUT_EN
module mul_iter_cnt #(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr_i,
  input  wire logic en_i,
  output logic      hit_o
);

  localparam logic [ITER_W-1:0] LAST = ITER_W'(MAX_ITER - 1);

  logic [ITER_W-1:0] cnt_q;
  logic [ITER_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and saturate on the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count starts at 0 on the first ADD cycle, so LAST marks the
  // MAX_ITER-th one.
  assign hit_o = en_i && (cnt_q == LAST);

endmodule
`endif
`default_nettype wire

// File: rtl/mul_controller.sv
`default_nettype none
// ============================================================================
//  Module  : mul_controller
//  Purpose : Sequencer for a repeated-addition multiplier. Accepts A then B on
//            the shared bus via valid/ready, adds A into P while decrementing
//            B until the datapath reports B==0, then pulses done.
//            Optional ADD-loop timeout guard: define MUL_TIMEOUT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module mul_controller
  import mul_ctrl_pkg::*;
#(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  wire logic clk,
  input  wire logic rst_n,
  mul_ctrl_if.master bus
);

  mul_state_e state_q;
  mul_state_e state_d;

  logic in_ready_d;
  logic ldA_d;
  logic ldB_d;
  logic ldP_d;
  logic clrP_d;
  logic decB_d;
  logic done_d;
  logic iter_clr;
  logic iter_hit;
  logic accept_start;
  logic enter_err;

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; abort overrides whatever the state decoded.
  always_comb begin
    state_d    = state_q;
    in_ready_d = 1'b0;
    ldA_d      = 1'b0;
    ldB_d      = 1'b0;
    ldP_d      = 1'b0;
    clrP_d     = 1'b0;
    decB_d     = 1'b0;
    done_d     = 1'b0;
    iter_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD_A;
      end
      LOAD_A: begin
        in_ready_d = 1'b1;
        ldA_d      = bus.in_valid;
        if (bus.in_valid) state_d = LOAD_B;
      end
      LOAD_B: begin
        in_ready_d = 1'b1;
        ldB_d      = bus.in_valid;
        clrP_d     = bus.in_valid;
        if (bus.in_valid) begin
          state_d  = ADD;
          iter_clr = 1'b1;
        end
      end
      ADD: begin
        if (bus.eqz) begin
          state_d = DONE;
        end else begin
          ldP_d  = 1'b1;
          decB_d = 1'b1;
          if (iter_hit) state_d = ERR;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d    = IDLE;
      in_ready_d = 1'b0;
      ldA_d      = 1'b0;
      ldB_d      = 1'b0;
      ldP_d      = 1'b0;
      clrP_d     = 1'b0;
      decB_d     = 1'b0;
      done_d     = 1'b0;
      iter_clr   = 1'b0;
    end
  end

  assign accept_start = (state_q == IDLE) && bus.start && !bus.abort;
  assign enter_err    = (state_d == ERR);

  assign bus.in_ready = in_ready_d;
  assign bus.ldA      = ldA_d;
  assign bus.ldB      = ldB_d;
  assign bus.ldP      = ldP_d;
  assign bus.clrP     = clrP_d;
  assign bus.decB     = decB_d;
  assign bus.done     = done_d;
  assign bus.busy     = (state_q != IDLE);

`ifdef MUL_TIMEOUT_EN
  logic err_q;

  mul_iter_cnt #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (iter_clr),
    .en_i  (state_q == ADD),
    .hit_o (iter_hit)
  );

  // Sticky timeout flag: raised on entering ERR, dropped on the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept_start) begin
      err_q <= 1'b0;
    end else if (enter_err) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_cfg;

  assign iter_hit   = 1'b0;
  assign bus.err    = 1'b0;
  assign unused_cfg = ^{accept_start, enter_err, iter_clr, ITER_W[0], MAX_ITER[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_controller.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mul_controller
//  Purpose : Self-checking bench for mul_controller with a behavioural
//            multiplier datapath on the shared operand bus.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mul_controller;
  import mul_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic force_eqz0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mul_ctrl_if bus ();

  mul_controller #(
    .ITER_W   (16),
    .MAX_ITER (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Datapath: A register, P accumulator, B down-counter and zero detect.
  logic [DATA_W-1:0] a_q, b_q, p_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      if (bus.ldA) a_q <= bus.data_in;
      if (bus.ldB) b_q <= bus.data_in;
      else if (bus.decB) b_q <= b_q - 1'b1;
      if (bus.clrP) p_q <= '0;
      else if (bus.ldP) p_q <= p_q + a_q;
    end
  end
  assign bus.eqz = force_eqz0 ? 1'b0 : (b_q == '0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: new inputs 1 time unit after the edge, outputs settle by +2.
  task automatic step(input bit st, input bit vld, input logic [DATA_W-1:0] d, input bit ab);
    @(posedge clk);
    #1;
    bus.start    = st;
    bus.in_valid = vld;
    bus.data_in  = d;
    bus.abort    = ab;
    #1;
  endtask

  // Reference: product is A*B mod 2^16; A accepted 1+sa cycles after the
  // start cycle, B 1+sb cycles later, then B adds, one zero-detect cycle,
  // and the done cycle.
  task automatic run_mul(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input int sa, input int sb, input bit noise);
    int a_cyc, b_cyc, exp_done, first, n_done, n_busy, n_ldp;
    logic [DATA_W-1:0] exp_p;
    logic st;
    a_cyc    = 1 + sa;
    b_cyc    = a_cyc + 1 + sb;
    exp_done = b_cyc + 2 + int'(b);
    exp_p    = a * b;
    first = -1; n_done = 0; n_busy = 0; n_ldp = 0;
    for (int c = 0; c <= exp_done + 1; c++) begin
      st = (c == 0) || (noise && c < exp_done && ($urandom_range(0, 2) == 0));
      step(st, (c == a_cyc) || (c == b_cyc),
           (c == a_cyc) ? a : ((c == b_cyc) ? b : DATA_W'($urandom)), 1'b0);
      if (bus.done === 1'b1) begin
        n_done++;
        if (first < 0) first = c;
      end
      if (bus.busy === 1'b1) n_busy++;
      if (bus.ldP === 1'b1) n_ldp++;
      if (c == exp_done + 1) check($sformatf("%s_busy_after", tag), {31'd0, bus.busy}, 32'd0);
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    check($sformatf("%s_done_cycle", tag), first, exp_done);
    check($sformatf("%s_done_count", tag), n_done, 1);
    check($sformatf("%s_busy_cycles", tag), n_busy, exp_done);
    check($sformatf("%s_add_count", tag), n_ldp, int'(b));
    check($sformatf("%s_product", tag), {16'd0, p_q}, {16'd0, exp_p});
  endtask

  initial begin
    int nd;
    int nl;
    rst_n = 1'b0;
    force_eqz0 = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in = '0;

    // Reset: everything quiet, even with requests on the inputs.
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_strobes", {27'd0, bus.ldA, bus.ldB, bus.ldP, bus.clrP, bus.decB}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0;
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Directed multiplies.
    run_mul("t1", 16'd5, 16'd3, 0, 0, 1'b0);
    run_mul("t2", 16'd7, 16'd0, 0, 0, 1'b0);
    run_mul("t3", 16'd9, 16'd4, 2, 3, 1'b0);

    // Abort after two adds.
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'd3, 1'b0);
    step(1'b0, 1'b1, 16'd10, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("abort_strobes", {30'd0, bus.ldP, bus.decB}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      if (i == 0) check("abort_idle", {31'd0, bus.busy}, 32'd0);
      if (bus.done === 1'b1) nd++;
    end
    check("abort_no_done", nd, 0);
    check("abort_p_kept", {16'd0, p_q}, 32'd6);
    run_mul("t4", 16'd6, 16'd2, 0, 0, 1'b0);

    // Start and abort together in IDLE: abort wins.
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check("start_abort_idle", {31'd0, bus.busy}, 32'd0);

    // Start pulses while busy are ignored.
    run_mul("t5", 16'd11, 16'd6, 1, 1, 1'b1);

    // Reset in the middle of ADD.
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'd2, 1'b0);
    step(1'b0, 1'b1, 16'd5, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    @(posedge clk); #1; rst_n = 1'b0; #1;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);

    // Randomized multiplies against the arithmetic model.
    for (int k = 0; k < 8; k++) begin
      run_mul($sformatf("rnd%0d", k), DATA_W'($urandom), DATA_W'($urandom_range(0, 12)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

`ifdef MUL_TIMEOUT_EN
    // Timeout: eqz held low, eight adds then ERR, no done.
    force_eqz0 = 1'b1;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'd1, 1'b0);
    step(1'b0, 1'b1, 16'd20, 1'b0);
    nd = 0; nl = 0;
    for (int c = 3; c <= 13; c++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      if (bus.done === 1'b1) nd++;
      if (bus.ldP === 1'b1) nl++;
      if (c == 11) check("to_err_raised", {31'd0, bus.err}, 32'd1);
      if (c == 12) check("to_idle", {31'd0, bus.busy}, 32'd0);
    end
    force_eqz0 = 1'b0;
    check("to_add_count", nl, 8);
    check("to_no_done", nd, 0);
    check("to_err_sticky", {31'd0, bus.err}, 32'd1);
    run_mul("t6", 16'd4, 16'd3, 0, 0, 1'b0);
    check("to_err_cleared", {31'd0, bus.err}, 32'd0);
`else
    nl = 0;
    check("err_tied", {31'd0, bus.err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
